// File: rtl/ahb_result_mailbox.sv
// AHB-Lite responder holding the classifier result mailbox.
// A bus master writes a 5-bit letter to DATA and commits it through DONE.
// The committed letter is handed to the consumer with a one-cycle valid pulse,
// and pending/overflow bookkeeping is kept until the consumer acknowledges.
module ahb_result_mailbox #(
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ahb_s0_haddr_i,
    input  logic        ahb_s0_hwrite_i,
    input  logic [2:0]  ahb_s0_hsize_i,
    input  logic [1:0]  ahb_s0_htrans_i,
    input  logic [31:0] ahb_s0_hwdata_i,
    output logic [31:0] ahb_s0_hrdata_o,
    output logic        ahb_s0_hready_o,
    output logic        ahb_s0_hresp_o,
    output logic [4:0]  letter_o,
    output logic        letter_valid_o,
    input  logic        letter_ack_i
);

    localparam logic [2:0] WS = WAIT_STATES[2:0];

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t           state, state_nxt;
    logic [2:0]       wcnt, wcnt_nxt;
    logic             ready, resp;
    logic             accept, legal;
    logic [1:0]       reg_sel;
    logic             is_write;
    logic             dp_done, wr_en, rd_en, commit, w1c;
    logic [4:0]       data_q, letter_q;
    logic             letter_valid_q;
    logic             pending, overflow;
    logic [CNT_W-1:0] count;
    logic [31:0]      count_ext, rdata_sel;
    logic             unused_bits;

    // Only offsets 0x0..0xC inside the 4 KB window exist; COUNT is read-only.
    assign legal = (ahb_s0_haddr_i[31:12] == BASE_ADDR[31:12]) &&
                   (ahb_s0_haddr_i[11:4] == 8'h00) &&
                   (ahb_s0_hsize_i == 3'b010) &&
                   !(ahb_s0_hwrite_i && (ahb_s0_haddr_i[3:2] == 2'b11));
    assign accept = ready && ahb_s0_htrans_i[1];

    // The data phase completes on the cycle where the wait counter has run out.
    assign dp_done = (state == ST_DATA) && (wcnt == 3'd0);
    assign wr_en   = dp_done && is_write;
    assign rd_en   = dp_done && !is_write;
    assign commit  = wr_en && (reg_sel == 2'b01) && ahb_s0_hwdata_i[0];
    assign w1c     = wr_en && (reg_sel == 2'b10) && ahb_s0_hwdata_i[1];

    assign unused_bits = ^{ahb_s0_haddr_i[1:0], ahb_s0_htrans_i[0], ahb_s0_hwdata_i[31:5]};

    // FSM state and wait counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            wcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state logic and bus handshake outputs; any ready cycle may accept a new address.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ready     = 1'b1;
        resp      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_DATA: begin
                ready = (wcnt == 3'd0);
                if (wcnt != 3'd0) wcnt_nxt = wcnt - 3'd1;
            end
            ST_ERR1: begin
                ready     = 1'b0;
                resp      = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: resp = 1'b1;
            default: ;
        endcase
        if (ready) begin
            if (ahb_s0_htrans_i[1]) begin
                if (legal) begin
                    state_nxt = ST_DATA;
                    wcnt_nxt  = WS;
                end else begin
                    state_nxt = ST_ERR1;
                end
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Capture register select and direction of each accepted legal transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_sel  <= 2'b00;
            is_write <= 1'b0;
        end else if (accept && legal) begin
            reg_sel  <= ahb_s0_haddr_i[3:2];
            is_write <= ahb_s0_hwrite_i;
        end
    end

    // Mailbox registers: commit has priority over ack, overflow set has priority over clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q         <= 5'd0;
            pending        <= 1'b0;
            overflow       <= 1'b0;
            count          <= '0;
            letter_q       <= 5'd0;
            letter_valid_q <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == 2'b00)) data_q <= ahb_s0_hwdata_i[4:0];
            if (commit) pending <= 1'b1;
            else if (letter_ack_i) pending <= 1'b0;
            if (commit && pending && !letter_ack_i) overflow <= 1'b1;
            else if (w1c) overflow <= 1'b0;
            if (commit) begin
                count    <= count + 1'b1;
                letter_q <= data_q;
            end
            letter_valid_q <= commit;
        end
    end

    // Read-back multiplexer; DONE reads as zero.
    always_comb begin
        count_ext              = '0;
        count_ext[CNT_W-1:0]   = count;
        rdata_sel              = 32'h0;
        case (reg_sel)
            2'b00:   rdata_sel = {27'h0, data_q};
            2'b01:   rdata_sel = 32'h0;
            2'b10:   rdata_sel = {30'h0, overflow, pending};
            default: rdata_sel = count_ext;
        endcase
    end

    assign ahb_s0_hready_o = ready;
    assign ahb_s0_hresp_o  = resp;
    assign ahb_s0_hrdata_o = rd_en ? rdata_sel : 32'h0;
    assign letter_o        = letter_q;
    assign letter_valid_o  = letter_valid_q;

endmodule

// File: tb/tb_ahb_result_mailbox.sv
// Bench for ahb_result_mailbox: instance 0 has no wait states and a 4-bit COUNT,
// instance 1 has two wait states and a 16-bit COUNT. A behavioural model tracks
// the mailbox contents per instance.
module tb_ahb_result_mailbox;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic        ack    [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [4:0]  letter [2];
    logic        lvalid [2];

    int total = 0;
    int passed = 0;

    logic [4:0]  m_data [2];
    logic [4:0]  m_letter [2];
    bit          m_pend [2];
    bit          m_ovf [2];
    int unsigned m_count [2];
    int unsigned m_mask [2] = '{32'd15, 32'd65535};

    always #5 clk = ~clk;

    ahb_result_mailbox #(.BASE_ADDR(32'hC000_0000), .WAIT_STATES(0), .CNT_W(4)) dut0 (
        .clk(clk), .resetn(resetn),
        .ahb_s0_haddr_i(haddr[0]), .ahb_s0_hwrite_i(hwrite[0]), .ahb_s0_hsize_i(hsize[0]),
        .ahb_s0_htrans_i(htrans[0]), .ahb_s0_hwdata_i(hwdata[0]), .ahb_s0_hrdata_o(hrdata[0]),
        .ahb_s0_hready_o(hready[0]), .ahb_s0_hresp_o(hresp[0]),
        .letter_o(letter[0]), .letter_valid_o(lvalid[0]), .letter_ack_i(ack[0]));

    ahb_result_mailbox #(.BASE_ADDR(32'hC000_0000), .WAIT_STATES(2), .CNT_W(16)) dut1 (
        .clk(clk), .resetn(resetn),
        .ahb_s0_haddr_i(haddr[1]), .ahb_s0_hwrite_i(hwrite[1]), .ahb_s0_hsize_i(hsize[1]),
        .ahb_s0_htrans_i(htrans[1]), .ahb_s0_hwdata_i(hwdata[1]), .ahb_s0_hrdata_o(hrdata[1]),
        .ahb_s0_hready_o(hready[1]), .ahb_s0_hresp_o(hresp[1]),
        .letter_o(letter[1]), .letter_valid_o(lvalid[1]), .letter_ack_i(ack[1]));

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        return (a[31:12] == 20'hC0000) && (a[11:4] == 8'h00) && (sz == 3'b010) &&
               !(wr && (a[3:2] == 2'b11));
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [1:0] off);
        case (off)
            2'd0:    return {27'h0, m_data[d]};
            2'd1:    return 32'h0;
            2'd2:    return {30'h0, m_ovf[d], m_pend[d]};
            default: return m_count[d];
        endcase
    endfunction

    task automatic m_write(input int d, input logic [1:0] off, input logic [31:0] wd, input bit ackc);
        bit c;
        c = (off == 2'd1) && wd[0];
        if (off == 2'd0) m_data[d] = wd[4:0];
        if (c) begin
            if (m_pend[d] && !ackc) m_ovf[d] = 1'b1;
            m_pend[d]   = 1'b1;
            m_count[d]  = (m_count[d] + 1) & m_mask[d];
            m_letter[d] = m_data[d];
        end else if (ackc) begin
            m_pend[d] = 1'b0;
        end
        if ((off == 2'd2) && wd[1]) m_ovf[d] = 1'b0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 5'd0; m_letter[i] = 5'd0; m_pend[i] = 1'b0; m_ovf[i] = 1'b0; m_count[i] = 0;
        end
    endtask

    // ---------------- bus driver (no checking) ----------------
    task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input bit ack_dp,
                        output logic [31:0] rd, output logic resp, output logic first_resp,
                        output int waits, output bit leak, output bit tmo);
        haddr[d] = a; hwrite[d] = wr; hsize[d] = sz; htrans[d] = 2'b10;
        @(posedge clk); #1;
        htrans[d] = 2'b00; haddr[d] = 32'h0; hwrite[d] = 1'b0; hwdata[d] = wd;
        waits = 0; leak = 1'b0; first_resp = hresp[d];
        while (hready[d] !== 1'b1 && waits < 20) begin
            if (hrdata[d] !== 32'h0) leak = 1'b1;
            waits++;
            @(posedge clk); #1;
        end
        tmo = (waits >= 20);
        if (wr && hrdata[d] !== 32'h0) leak = 1'b1;
        rd = hrdata[d]; resp = hresp[d];
        if (ack_dp) ack[d] = 1'b1;
        @(posedge clk); #1;
        ack[d] = 1'b0;
    endtask

    task automatic ack_pulse(input int d);
        ack[d] = 1'b1;
        @(posedge clk); #1;
        ack[d] = 1'b0;
        m_pend[d] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({hready[d], hresp[d], hrdata[d], letter[d], lvalid[d]} !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0})
                $display("FAIL reset_outputs[%0d]: got %b %b %h %h %b want 1 0 0 0 0", d, hready[d], hresp[d], hrdata[d], letter[d], lvalid[d]);
            else passed++;
            for (int r = 0; r < 4; r++) begin
                xfer(d, 32'hC000_0000 + 32'(r * 4), 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
                total++;
                if (rd !== 32'h0 || rs !== 1'b0 || to) $display("FAIL reset_reg[%0d][%0d]: got %h resp %b want 0", d, r, rd, rs);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        haddr[0] = 32'hC000_0000; hwrite[0] = 1'b1; hsize[0] = 3'b010; htrans[0] = 2'b10;
        @(posedge clk); #1;
        total++;
        if (hready[0] !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", hready[0]); else passed++;
        haddr[0] = 32'hC000_0004; hwdata[0] = 32'h13;
        @(posedge clk); #1;
        total++;
        if ({hready[0], lvalid[0]} !== 2'b10) $display("FAIL b2b_ready2: got %b%b want 10", hready[0], lvalid[0]); else passed++;
        htrans[0] = 2'b00; hwrite[0] = 1'b0; hwdata[0] = 32'h1;
        @(posedge clk); #1;
        m_write(0, 2'd0, 32'h13, 1'b0);
        m_write(0, 2'd1, 32'h1, 1'b0);
        total++;
        if ({letter[0], lvalid[0]} !== {5'h13, 1'b1}) $display("FAIL b2b_letter: got %h/%b want 13/1", letter[0], lvalid[0]); else passed++;
        @(posedge clk); #1;
        total++;
        if (lvalid[0] !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", lvalid[0]); else passed++;
        xfer(0, 32'hC000_000C, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== m_read(0, 2'd3) || rd !== 32'h1) $display("FAIL b2b_count: got %h want 1", rd); else passed++;
        xfer(0, 32'hC000_0008, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== m_read(0, 2'd2) || rd !== 32'h1) $display("FAIL b2b_status: got %h want 1", rd); else passed++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, wd; logic rs, fr; int w; bit lk, to;
        wd = $urandom() | 32'h10;
        xfer(1, 32'hC000_0000, 1'b1, 3'b010, wd, 1'b0, rd, rs, fr, w, lk, to);
        m_write(1, 2'd0, wd, 1'b0);
        total++;
        if (w != 2 || rs !== 1'b0) $display("FAIL ws_write: got waits %0d resp %b want 2 0", w, rs); else passed++;
        xfer(1, 32'hC000_0000, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (w != 2 || lk) $display("FAIL ws_read_wait: got waits %0d leak %b want 2 0", w, lk); else passed++;
        total++;
        if (rd !== m_read(1, 2'd0)) $display("FAIL ws_read_data: got %h want %h", rd, m_read(1, 2'd0)); else passed++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        logic [31:0] ea [4] = '{32'hC000_0010, 32'hC000_0000, 32'hC000_000C, 32'hD000_0000};
        logic [2:0]  es [4] = '{3'b010, 3'b001, 3'b010, 3'b010};
        logic        ew [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xfer(0, ea[i], ew[i], es[i], 32'h1F, 1'b0, rd, rs, fr, w, lk, to);
            total++;
            if ({fr, rs} !== 2'b11 || w != 1) $display("FAIL err_resp[%0d]: got err1 %b err2 %b waits %0d want 1 1 1", i, fr, rs, w);
            else passed++;
        end
        xfer(0, 32'hC000_0000, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== m_read(0, 2'd0)) $display("FAIL err_data_kept: got %h want %h", rd, m_read(0, 2'd0)); else passed++;
        xfer(0, 32'hC000_000C, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== m_read(0, 2'd3)) $display("FAIL err_count_kept: got %h want %h", rd, m_read(0, 2'd3)); else passed++;
    endtask

    task automatic test_status();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        ack_pulse(0);
        xfer(0, 32'hC000_0008, 1'b1, 3'b010, 32'h2, 1'b0, rd, rs, fr, w, lk, to);
        m_write(0, 2'd2, 32'h2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            xfer(0, 32'hC000_0004, 1'b1, 3'b010, 32'h1, 1'b0, rd, rs, fr, w, lk, to);
            m_write(0, 2'd1, 32'h1, 1'b0);
        end
        xfer(0, 32'hC000_0008, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== 32'h3 || rd !== m_read(0, 2'd2)) $display("FAIL status_ovf: got %h want 3", rd); else passed++;
        xfer(0, 32'hC000_0008, 1'b1, 3'b010, 32'h2, 1'b0, rd, rs, fr, w, lk, to);
        m_write(0, 2'd2, 32'h2, 1'b0);
        xfer(0, 32'hC000_0008, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== 32'h1) $display("FAIL status_w1c: got %h want 1", rd); else passed++;
        ack_pulse(0);
        xfer(0, 32'hC000_0008, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== 32'h0) $display("FAIL status_ack: got %h want 0", rd); else passed++;
    endtask

    task automatic test_commit_ack();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        xfer(0, 32'hC000_0004, 1'b1, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if ({lvalid[0], rs} !== 2'b00) $display("FAIL done_bit0_zero: got valid %b resp %b want 0 0", lvalid[0], rs); else passed++;
        xfer(0, 32'hC000_000C, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== m_read(0, 2'd3)) $display("FAIL done_bit0_count: got %h want %h", rd, m_read(0, 2'd3)); else passed++;
        xfer(0, 32'hC000_0004, 1'b1, 3'b010, 32'h1, 1'b0, rd, rs, fr, w, lk, to);
        m_write(0, 2'd1, 32'h1, 1'b0);
        xfer(0, 32'hC000_0004, 1'b1, 3'b010, 32'h1, 1'b1, rd, rs, fr, w, lk, to);
        m_write(0, 2'd1, 32'h1, 1'b1);
        xfer(0, 32'hC000_0008, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== 32'h1 || rd !== m_read(0, 2'd2)) $display("FAIL commit_ack: got %h want 1", rd); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, wd; logic rs, fr; int w; bit lk, to;
        int d, op; logic [1:0] off; logic [31:0] ia [3] = '{32'hC000_0FF0, 32'hC000_0000, 32'hC000_000C};
        for (int n = 0; n < 80; n++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 5);
            wd = $urandom();
            case (op)
                0: begin
                    xfer(d, 32'hC000_0000, 1'b1, 3'b010, wd, 1'b0, rd, rs, fr, w, lk, to);
                    m_write(d, 2'd0, wd, 1'b0);
                end
                1: begin
                    if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
                    xfer(d, 32'hC000_0004, 1'b1, 3'b010, wd, 1'b0, rd, rs, fr, w, lk, to);
                    m_write(d, 2'd1, wd, 1'b0);
                    total++;
                    if ({letter[d], lvalid[d]} !== {m_letter[d], wd[0]})
                        $display("FAIL rnd_commit[%0d]: got %h/%b want %h/%b", n, letter[d], lvalid[d], m_letter[d], wd[0]);
                    else passed++;
                end
                2: begin
                    xfer(d, 32'hC000_0008, 1'b1, 3'b010, wd, 1'b0, rd, rs, fr, w, lk, to);
                    m_write(d, 2'd2, wd, 1'b0);
                end
                3: begin
                    off = 2'($urandom_range(0, 3));
                    xfer(d, 32'hC000_0000 + {28'h0, off, 2'b00}, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
                    total++;
                    if (rd !== m_read(d, off) || rs !== 1'b0 || lk)
                        $display("FAIL rnd_read[%0d] inst %0d off %0d: got %h resp %b want %h", n, d, off, rd, rs, m_read(d, off));
                    else passed++;
                end
                4: ack_pulse(d);
                default: begin
                    op = $urandom_range(0, 2);
                    xfer(d, ia[op], 1'b1, (op == 1) ? 3'b000 : 3'b010, wd, 1'b0, rd, rs, fr, w, lk, to);
                    total++;
                    if ({fr, rs} !== 2'b11 || w != 1) $display("FAIL rnd_err[%0d]: got %b%b waits %0d want 11 1", n, fr, rs, w);
                    else passed++;
                end
            endcase
            if (to) begin
                total++;
                $display("FAIL rnd_timeout[%0d]: hready never returned", n);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to; int n;
        n = 16 - int'(m_count[0]);
        for (int i = 0; i < n; i++) begin
            xfer(0, 32'hC000_0004, 1'b1, 3'b010, 32'h1, 1'b0, rd, rs, fr, w, lk, to);
            m_write(0, 2'd1, 32'h1, 1'b0);
        end
        xfer(0, 32'hC000_000C, 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
        total++;
        if (rd !== 32'h0 || rd !== m_read(0, 2'd3)) $display("FAIL count_wrap: got %h want 0", rd); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic rs, fr; int w; bit lk, to;
        xfer(1, 32'hC000_0000, 1'b1, 3'b010, 32'h1E, 1'b0, rd, rs, fr, w, lk, to);
        xfer(1, 32'hC000_0004, 1'b1, 3'b010, 32'h1, 1'b0, rd, rs, fr, w, lk, to);
        haddr[1] = 32'hC000_0000; hwrite[1] = 1'b1; hsize[1] = 3'b010; htrans[1] = 2'b10;
        @(posedge clk); #1;
        htrans[1] = 2'b00; hwdata[1] = 32'h5;
        total++;
        if ({hready[1], letter[1]} !== {1'b0, 5'h1E}) $display("FAIL mid_wait_pre: got %b/%h want 0/1e", hready[1], letter[1]); else passed++;
        resetn = 1'b0;
        #1;
        total++;
        if ({hready[1], hresp[1], hrdata[1], letter[1], lvalid[1]} !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0})
            $display("FAIL mid_wait_reset: got %b %b %h %h %b want 1 0 0 0 0", hready[1], hresp[1], hrdata[1], letter[1], lvalid[1]);
        else passed++;
        @(posedge clk); #1;
        resetn = 1'b1;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) begin
                xfer(d, 32'hC000_0000 + 32'(r * 4), 1'b0, 3'b010, 32'h0, 1'b0, rd, rs, fr, w, lk, to);
                total++;
                if (rd !== m_read(d, 2'(r))) $display("FAIL post_reset[%0d][%0d]: got %h want %h", d, r, rd, m_read(d, 2'(r)));
                else passed++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            haddr[d] = 32'h0; hwrite[d] = 1'b0; hsize[d] = 3'b010; htrans[d] = 2'b00;
            hwdata[d] = 32'h0; ack[d] = 1'b0;
        end
        m_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_status();
        test_commit_ack();
        test_random();
        test_count_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
